pipe_skid_stage: RTL and testbench



---
 rtl/pipe_skid_stage.sv | 127 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Handshaked multi-lane pipeline register with a two-entry skid
//            buffer, flush, per-beat kill and zeroed bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int CTRL_W = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic                    kill,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [1:0]              occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic                    r_inReady;
    logic [LANES*DATA_W-1:0] r_mainData;
    logic [CTRL_W-1:0]       r_mainCtrl;
    logic [LANES*DATA_W-1:0] r_skidData;
    logic [CTRL_W-1:0]       r_skidCtrl;

    logic w_acc;
    logic w_take;
    logic w_loadMainIn;
    logic w_loadMainSkid;
    logic w_loadSkid;

    // A killed beat still handshakes upstream (in_ready is honoured) but is never stored.
    assign w_acc     = in_valid & r_inReady & ~kill;
    assign out_valid = (r_state != EMPTY);
    assign w_take    = out_valid & out_ready;

    always_comb begin
        w_stateNext    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        if (flush) begin
            w_stateNext = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        w_stateNext  = ONE;
                        w_loadMainIn = 1'b1;
                    end
                end
                ONE: begin
                    if (w_acc && w_take) begin
                        w_loadMainIn = 1'b1;
                    end else if (w_acc) begin
                        w_stateNext = FULL;
                        w_loadSkid  = 1'b1;
                    end else if (w_take) begin
                        w_stateNext = EMPTY;
                    end
                end
                FULL: begin
                    if (w_take) begin
                        w_stateNext    = ONE;
                        w_loadMainSkid = 1'b1;
                    end
                end
                default: w_stateNext = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= EMPTY;
            r_inReady  <= 1'b1;
            r_mainData <= '0;
            r_mainCtrl <= '0;
            r_skidData <= '0;
            r_skidCtrl <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_inReady <= (w_stateNext != FULL);
            if (w_loadMainIn) begin
                r_mainData <= in_data;
                r_mainCtrl <= in_ctrl;
            end else if (w_loadMainSkid) begin
                r_mainData <= r_skidData;
                r_mainCtrl <= r_skidCtrl;
            end
            if (w_loadSkid) begin
                r_skidData <= in_data;
                r_skidCtrl <= in_ctrl;
            end
        end
    end

    assign in_ready  = r_inReady;
    assign out_data  = out_valid ? r_mainData : '0;
    assign out_ctrl  = out_valid ? r_mainCtrl : '0;
    assign occupancy = r_state;

    // Encoding 3 has no meaning; the transition logic can never produce it.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (r_state != 2'd3);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : Directed self-checking bench for pipe_skid_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int CTRL_W = 12;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0]       in_ctrl = '0;
    logic                    kill = 1'b0;
    logic                    flush = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [LANES*DATA_W-1:0] out_data;
    logic [CTRL_W-1:0]       out_ctrl;
    logic [1:0]              occupancy;

    int nChecks = 0;
    int nErrors = 0;

    pipe_skid_stage #(.DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .kill(kill), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Every lane gets a distinct pattern derived from lane 0 so lane swaps are visible.
    function automatic logic [LANES*DATA_W-1:0] mkData(input logic [15:0] v);
        return {v ^ 16'hF000, v ^ 16'h0F00, v ^ 16'h00F0, v};
    endfunction

    function automatic logic [CTRL_W-1:0] mkCtrl(input logic [15:0] v);
        return v[11:0] ^ 12'h5A5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkOut(input string tag, input logic expValid, input logic [15:0] v,
                          input logic [1:0] expOcc, input logic expReady);
        chk({tag, ".valid"}, 64'(out_valid), 64'(expValid));
        chk({tag, ".data"},  64'(out_data), expValid ? 64'(mkData(v)) : 64'd0);
        chk({tag, ".ctrl"},  64'(out_ctrl), expValid ? 64'(mkCtrl(v)) : 64'd0);
        chk({tag, ".occ"},   64'(occupancy), 64'(expOcc));
        chk({tag, ".ready"}, 64'(in_ready), 64'(expReady));
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        in_valid = v;
        in_data  = mkData(d);
        in_ctrl  = mkCtrl(d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset asserted before any clock edge must clear outputs immediately.
        #1 reset = 1'b0;
        in_valid = 1'b1; in_data = {$urandom, $urandom}; in_ctrl = 12'($urandom);
        out_ready = 1'b1; kill = 1'($urandom); flush = 1'b0;
        #1;
        chkOut("rst_async", 1'b0, 16'h0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            in_data = {$urandom, $urandom}; in_ctrl = 12'($urandom); kill = 1'($urandom);
            chkOut("rst_hold", 1'b0, 16'h0, 2'd0, 1'b1);
        end
        reset = 1'b1; kill = 1'b0; drive(1'b0, 16'h0);

        // Streaming: one beat per cycle, one cycle latency.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 16'(i));
            step();
            chkOut($sformatf("stream%0d", i), 1'b1, 16'(i), 2'd1, 1'b1);
        end
        drive(1'b0, 16'h0);
        step();
        chkOut("stream_end", 1'b0, 16'h0, 2'd0, 1'b1);

        // Backpressure into the skid register.
        drive(1'b1, 16'hAAAA);
        step();
        chkOut("bp_a", 1'b1, 16'hAAAA, 2'd1, 1'b1);
        drive(1'b1, 16'hBBBB); out_ready = 1'b0;
        step();
        chkOut("bp_full", 1'b1, 16'hAAAA, 2'd2, 1'b0);
        drive(1'b0, 16'h0);
        step();
        chkOut("bp_hold", 1'b1, 16'hAAAA, 2'd2, 1'b0);
        out_ready = 1'b1;
        step();
        chkOut("bp_b", 1'b1, 16'hBBBB, 2'd1, 1'b1);
        step();
        chkOut("bp_drain", 1'b0, 16'h0, 2'd0, 1'b1);

        // Kill squashes beat 2 while beat 1 is taken.
        drive(1'b1, 16'h0001);
        step();
        chkOut("kill_b1", 1'b1, 16'h0001, 2'd1, 1'b1);
        drive(1'b1, 16'h0002); kill = 1'b1;
        step();
        chkOut("kill_b2", 1'b0, 16'h0, 2'd0, 1'b1);
        drive(1'b1, 16'h0003); kill = 1'b0;
        step();
        chkOut("kill_b3", 1'b1, 16'h0003, 2'd1, 1'b1);
        drive(1'b0, 16'h0);
        step();
        chkOut("kill_end", 1'b0, 16'h0, 2'd0, 1'b1);

        // Flush from FULL with a beat offered in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 16'h1111);
        step();
        drive(1'b1, 16'h2222);
        step();
        chkOut("fl_full", 1'b1, 16'h1111, 2'd2, 1'b0);
        drive(1'b1, 16'h3333); flush = 1'b1;
        step();
        chkOut("fl_empty", 1'b0, 16'h0, 2'd0, 1'b1);
        flush = 1'b0; drive(1'b0, 16'h0); out_ready = 1'b1;
        step();
        chkOut("fl_after", 1'b0, 16'h0, 2'd0, 1'b1);

        // Flush in ONE while an accepted beat and a take coincide.
        drive(1'b1, 16'h4444);
        step();
        chkOut("fl1_one", 1'b1, 16'h4444, 2'd1, 1'b1);
        drive(1'b1, 16'h5555); flush = 1'b1;
        step();
        chkOut("fl1_empty", 1'b0, 16'h0, 2'd0, 1'b1);
        flush = 1'b0; drive(1'b0, 16'h0);

        // Async reset while FULL, between clock edges.
        out_ready = 1'b0;
        drive(1'b1, 16'h6666);
        step();
        drive(1'b1, 16'h7777);
        step();
        chkOut("ar_full", 1'b1, 16'h6666, 2'd2, 1'b0);
        drive(1'b0, 16'h0);
        #2 reset = 1'b0;
        #1;
        chkOut("ar_mid", 1'b0, 16'h0, 2'd0, 1'b1);
        step();
        reset = 1'b1; out_ready = 1'b1;
        drive(1'b1, 16'h8888);
        step();
        chkOut("ar_next", 1'b1, 16'h8888, 2'd1, 1'b1);
        drive(1'b0, 16'h0);
        step();
        chkOut("ar_end", 1'b0, 16'h0, 2'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
